// File: rtl/cba_pkg.sv
// cba_pkg: shared defaults and operand type for the carry-bypass adder.
package cba_pkg;

    localparam int CBA_WIDTH      = 32;
    localparam int CBA_BLOCK      = 4;
    localparam int CBA_NUM_BLOCKS = CBA_WIDTH / CBA_BLOCK;

    typedef logic [CBA_WIDTH-1:0] word_t;

endpackage

// File: rtl/cba_skip_block.sv
// cba_skip_block: BLOCK-bit ripple adder whose carry-out bypasses the ripple
// chain when every bit of the block propagates.
module cba_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++)
            c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end

    assign sum     = p ^ c[BLOCK-1:0];
    assign cout    = &p ? cin : c[BLOCK];
    assign msb_cin = c[BLOCK-1];

endmodule

// File: rtl/carry_bypass_adder.sv
// carry_bypass_adder: registered carry-skip adder producing sum, cout and signed overflow.
// Define CBA_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module carry_bypass_adder
    import cba_pkg::*;
#(
    parameter int WIDTH = CBA_WIDTH,
    parameter int BLOCK = CBA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int NB = WIDTH / BLOCK;

    if (BLOCK < 2 || WIDTH % BLOCK != 0) begin : bad_params
        $error("carry_bypass_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
    end

    logic [WIDTH-1:0] op_a, op_b;
    logic             op_cin, op_valid;

`ifdef CBA_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            op_valid <= 1'b0;
        end else begin
            op_a     <= a;
            op_b     <= b;
            op_cin   <= cin;
            op_valid <= in_valid;
        end
    end
`else
    assign op_a     = a;
    assign op_b     = b;
    assign op_cin   = cin;
    assign op_valid = in_valid;
`endif

    logic [WIDTH-1:0] s;
    logic             c_out, c_msb;

    // Each block's carry is a separate net so the chain stays a simple series path.
    for (genvar k = 0; k < NB; k++) begin : g
        logic ci, co, mc;
        if (k == 0) begin : f
            assign ci = op_cin;
        end else begin : r
            assign ci = g[k-1].co;
        end
        cba_skip_block #(.BLOCK(BLOCK)) u_blk (
            .a       (op_a[k*BLOCK +: BLOCK]),
            .b       (op_b[k*BLOCK +: BLOCK]),
            .cin     (ci),
            .sum     (s[k*BLOCK +: BLOCK]),
            .cout    (co),
            .msb_cin (mc)
        );
        if (k == NB - 1) begin : l
            assign c_out = co;
            assign c_msb = mc;
        end else begin : n
            logic unused_mc;
            assign unused_mc = mc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            of        <= 1'b0;
        end else begin
            out_valid <= op_valid;
            if (op_valid) begin
                sum  <= s;
                cout <= c_out;
                of   <= c_msb ^ c_out;
            end
        end
    end

endmodule

// File: tb/tb_carry_bypass_adder.sv
// tb_carry_bypass_adder: randomized scoreboard bench for carry_bypass_adder
// against an arithmetic reference model; honours CBA_INPUT_REG_EN latency.
module tb_carry_bypass_adder;
    import cba_pkg::*;

    localparam int W = CBA_WIDTH;
`ifdef CBA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic  c;
        word_t s;
        logic  o;
    } res_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  in_valid = 1'b0;
    logic  cin = 1'b0;
    word_t a = '0;
    word_t b = '0;
    word_t sum;
    logic  cout, of, out_valid;

    res_t sb[$];
    res_t last_exp = '0;
    res_t exp_r;
    logic [1:0] vhist;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    carry_bypass_adder #(.WIDTH(W), .BLOCK(CBA_BLOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .of        (of)
    );

    function automatic res_t model(word_t x, word_t y, logic ci);
        logic [W:0] t;
        res_t r;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.c = t[W];
        r.s = t[W-1:0];
        r.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic check(string name, res_t e);
        compared++;
        if ({cout, sum, of} !== e) begin
            mismatched++;
            $display("FAIL %s: got cout=%b sum=%h of=%b, required cout=%b sum=%h of=%b at %0t",
                     name, cout, sum, of, e.c, e.s, e.o, $time);
        end
    endtask

    // in_valid history: out_valid must echo in_valid from LAT edges earlier.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) vhist <= '0;
        else        vhist <= {vhist[0], in_valid};

    always @(negedge clk) begin
        if (rst_n) begin
            compared++;
            if (out_valid !== vhist[LAT-1]) begin
                mismatched++;
                $display("FAIL valid_timing: out_valid=%b required=%b at %0t", out_valid, vhist[LAT-1], $time);
            end
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: sum=%h with empty scoreboard at %0t", sum, $time);
                end else begin
                    exp_r = sb.pop_front();
                    check("result", exp_r);
                    last_exp = exp_r;
                end
            end else begin
                check("hold", last_exp);
            end
        end
    end

    task automatic send(word_t x, word_t y, logic ci);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        sb.push_back(model(x, y, ci));
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic word_t pick();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        compared++;
        if ({out_valid, cout, sum, of} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got valid=%b cout=%b sum=%h of=%b, required all 0", out_valid, cout, sum, of);
        end
        rst_n = 1'b1;
        idle(2);

        send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        send(32'h80000000, 32'hFFFFFFFF, 1'b0);
        idle(1);
        send(32'h12345678, 32'h80000000, 1'b0);
        send(32'h12345678, 32'h12345670, 1'b1);
        idle(2);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send(32'hFFFFF999, 32'h00000111, 1'b0);
        send(32'h00000420, 32'h00000420, 1'b1);
        idle(3);
        send(32'hFFFFFFFF, 32'h00000000, 1'b1);
        send(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
        drain();

        send(32'h11111111, 32'h22222222, 1'b0);
        send(32'h0F0F0F0F, 32'h01010101, 1'b1);
        send(32'hDEADBEEF, 32'h01234567, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, cout, sum, of} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: got valid=%b cout=%b sum=%h of=%b, required all 0", out_valid, cout, sum, of);
        end
        sb.delete();
        last_exp = '0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        send(32'hFFFFFFFF, 32'h00000000, 1'b1);
        send(32'h55555555, 32'hAAAAAAAA, 1'b1);
        drain();

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else send(pick(), pick(), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
